byte_stripping: RTL
===================

# byte_stripping

Transmit-side lane splitter that sits directly upstream of `byte_unstripping`. It takes a byte stream at the `clk_2f` rate and distributes consecutive bytes alternately to stripe 0 and stripe 1. Each stripe pair is presented for two `clk_2f` cycles, which is one `clk_f` frame. An odd trailing byte is flushed with only `valid_stripe_0` set.

## Interface
Parameters:
- `COUNT_W`, default 8: width of the emitted-frame counter.

Ports:
- `clk_2f` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `data_in` input 8: input byte.
- `valid_in` input 1: `data_in` is accepted on every rising edge where this is high; no backpressure.
- `data_stripe_0` output 8: lane 0 byte (even bytes of the stream).
- `data_stripe_1` output 8: lane 1 byte (odd bytes of the stream).
- `valid_stripe_0` output 1: lane 0 byte valid for the current frame.
- `valid_stripe_1` output 1: lane 1 byte valid for the current frame.
- `frame_phase` output 1: free-running frame phase. Stripe outputs change only on edges where `frame_phase`=1.
- `lane_sel` output 1: lane that receives the next accepted byte.
- `frame_count` output `COUNT_W`: number of emitted frames with at least one valid lane; wraps modulo 2^`COUNT_W`.

## Operation
Internal state:
- `phase`: toggles every cycle.
- `lane`: lane pointer.
- `hold_0`: staging register for a pending lane 0 byte.
- `pair_0`, `pair_1`, `pair_full`: one-pair buffer.

Accept path (every edge with `valid_in`=1):
- `lane`=0: `hold_0` <= `data_in`; `lane` <= 1.
- `lane`=1: `pair_0` <= `hold_0`, `pair_1` <= `data_in`, `pair_full` <= 1; `lane` <= 0.

Emit path, evaluated only on strobe edges (edges where `phase`=1), in priority order:
1. `pair_full`=1: stripes <= `pair_0`/`pair_1`, both valids <= 1, `frame_count`+1. `pair_full` clears unless a new pair loads on the same edge; a load wins and `pair_full` stays 1.
2. Flush: `pair_full`=0, `lane`=1 (lane 0 byte pending) and `valid_in`=0:
   - `data_stripe_0` <= `hold_0`, `valid_stripe_0` <= 1, `valid_stripe_1` <= 0.
   - `data_stripe_1` holds its value.
   - `lane` <= 0; `frame_count`+1.
3. Otherwise: both valids <= 0; both data outputs hold their previous values.

Rules:
- When `valid_in`=1 on a strobe edge with `lane`=1, the byte completes the pair; no flush occurs.
- On non-strobe edges, stripe outputs and `frame_count` hold.
- Overflow cannot occur at ≤1 byte per cycle. A completed pair is always emitted by the next strobe edge, before another pair can complete.
- Outputs are registered. No combinational path from inputs to outputs except `lane_sel` and `frame_phase`, which are register copies.

## Timing
Reset value of every output and internal register is 0:
- `phase`=0, `lane`=0, `pair_full`=0, `hold_0`/`pair_*`=0.
- All stripe data and valids = 0; `frame_count`=0.

Reset is asynchronous. Asserting it mid-frame discards any pending `hold_0` or pair immediately. The first edge after release has `phase`=0 (non-strobe).

Latency from the edge completing a pair to stripes valid:
- 1 edge if the pair completes on a non-strobe edge.
- 2 edges if it completes on a strobe edge.

Stripe outputs are stable for exactly 2 cycles between updates. Downstream samples them once per `clk_f` frame.

## Test plan
- **Reset:** assert `reset` asynchronously between edges -> all outputs 0 immediately. Release -> first edge non-strobe, `frame_phase` becomes 1.
- **Continuous stream:** after reset, drive `valid_in`=1 with bytes 0x10,0x11,0x12,0x13 on edges 1-4 ->
  - edge 2: strobe, both valids 0.
  - edge 4: stripes 0x10/0x11, both valids 1.
  - edge 6: stripes 0x12/0x13, both valids 1.
  - `frame_count`=2.
- **Odd byte flush:** single byte 0xA5 on edge 1, `valid_in`=0 afterwards -> edge 2: `data_stripe_0`=0xA5, `valid_stripe_0`=1, `valid_stripe_1`=0, `lane_sel`=0.
- **Pair completes on strobe edge:** bytes 0x01 on edge 1, 0x02 on edge 2 (strobe) -> edge 2: no output. Edge 4: 0x01/0x02 valid.
- **Gapped input:** bytes 0x30 on edge 2, 0x31 on edge 5 ->
  - edge 2 (strobe, `lane`=0): no flush, valids 0.
  - edge 4 (strobe, `lane`=1, `valid_in`=0): flushes 0x30 alone.
  - edge 5: 0x31 goes to lane 0.
  - edge 6: flushes 0x31 on `data_stripe_0`.
- **Counter wrap and mid-operation reset:**
  - With `COUNT_W`=2, emit 5 frames -> `frame_count` reads 1.
  - Assert `reset` while a pair is pending -> pair never appears after release.

Source files
------------

// File: rtl/byte_stripping.sv
// byte_stripping
//   Transmit-side lane splitter. Bytes arriving at the clk_2f rate are
//   dealt alternately to stripe 0 (even bytes) and stripe 1 (odd bytes).
//   A completed pair is presented on both stripes for one clk_f frame,
//   which is two clk_2f cycles. An odd trailing byte is flushed alone on
//   stripe 0.
//
// Ports
//   clk_2f          : single clock, all state changes on its rising edge
//   reset           : asynchronous, active-high reset
//   data_in         : input byte
//   valid_in        : data_in accepted on every edge where high (no backpressure)
//   data_stripe_0   : lane 0 byte (even bytes of the stream)
//   data_stripe_1   : lane 1 byte (odd bytes of the stream)
//   valid_stripe_0  : lane 0 byte valid for the current frame
//   valid_stripe_1  : lane 1 byte valid for the current frame
//   frame_phase     : free-running frame phase; stripes update only on
//                     edges where it is 1
//   lane_sel        : lane that receives the next accepted byte
//   frame_count     : frames emitted with at least one valid lane (wraps)
module byte_stripping #(
  parameter int COUNT_W = 8
) (
  input  logic               clk_2f,
  input  logic               reset,
  input  logic [7:0]         data_in,
  input  logic               valid_in,
  output logic [7:0]         data_stripe_0,
  output logic [7:0]         data_stripe_1,
  output logic               valid_stripe_0,
  output logic               valid_stripe_1,
  output logic               frame_phase,
  output logic               lane_sel,
  output logic [COUNT_W-1:0] frame_count
);

  logic       phase;
  logic       lane;
  logic [7:0] hold_0;
  logic [7:0] pair_0;
  logic [7:0] pair_1;
  logic       pair_full;

  // A byte arriving while lane 1 is selected completes a pair this edge.
  logic       pair_load;
  assign pair_load = valid_in && lane;

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      phase          <= 1'b0;
      lane           <= 1'b0;
      hold_0         <= 8'h00;
      pair_0         <= 8'h00;
      pair_1         <= 8'h00;
      pair_full      <= 1'b0;
      data_stripe_0  <= 8'h00;
      data_stripe_1  <= 8'h00;
      valid_stripe_0 <= 1'b0;
      valid_stripe_1 <= 1'b0;
      frame_count    <= '0;
    end else begin
      phase <= ~phase;

      // Accept path: stage lane 0 byte, or complete the pair with lane 1.
      if (valid_in) begin
        if (!lane) begin
          hold_0 <= data_in;
          lane   <= 1'b1;
        end else begin
          pair_0    <= hold_0;
          pair_1    <= data_in;
          pair_full <= 1'b1;
          lane      <= 1'b0;
        end
      end

      // Emit path, only on strobe edges (phase=1 marks the frame boundary).
      if (phase) begin
        if (pair_full) begin
          data_stripe_0  <= pair_0;
          data_stripe_1  <= pair_1;
          valid_stripe_0 <= 1'b1;
          valid_stripe_1 <= 1'b1;
          frame_count    <= frame_count + 1'b1;
          // A pair loading on this same edge keeps the buffer occupied.
          if (!pair_load)
            pair_full <= 1'b0;
        end else if (lane && !valid_in) begin
          // Odd trailing byte: send it alone, stripe 1 data is left as is.
          data_stripe_0  <= hold_0;
          valid_stripe_0 <= 1'b1;
          valid_stripe_1 <= 1'b0;
          lane           <= 1'b0;
          frame_count    <= frame_count + 1'b1;
        end else begin
          valid_stripe_0 <= 1'b0;
          valid_stripe_1 <= 1'b0;
        end
      end
    end
  end

  assign frame_phase = phase;
  assign lane_sel    = lane;

endmodule
